// File: rtl/branch_resolve_stage.sv
// Branch/jump resolution stage following the ALU: evaluates branch conditions,
// produces redirect target and link value, and holds the EX/MEM pipeline register.
module branch_resolve_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf,
  input  logic            alu_zf,
  input  logic            alu_vf,
  input  logic            alu_sf,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_mem_to_reg,
  input  logic            stall,
  input  logic            flush,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_rs2,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct3,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign_exc
);

  logic            cond;
  logic            is_jump;
  logic            live;
  logic            take;
  logic            misaligned;
  logic            keep;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;

  // Branch conditions are derived from the flags of rs1-rs2.
  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = alu_zf;
      3'b001:  cond = !alu_zf;
      3'b100:  cond = alu_sf != alu_vf;
      3'b101:  cond = alu_sf == alu_vf;
      3'b110:  cond = !alu_cf;
      3'b111:  cond = alu_cf;
      default: cond = 1'b0;
    endcase
  end

  // The instruction in EX while a redirect is being issued is wrong-path.
  assign is_jump    = ex_jal || ex_jalr;
  assign live       = ex_valid && !redirect_valid;
  assign take       = live && (is_jump || (ex_branch && cond));
  assign target     = ex_jalr ? {alu_r[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
  assign misaligned = target[1:0] != 2'b00;
  assign link       = ex_pc + XLEN'(4);
  assign keep       = live && !(take && misaligned);

  // Stall holds the register but never repeats a redirect or exception pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rs2        <= '0;
      mem_rd         <= '0;
      mem_funct3     <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      misalign_exc   <= 1'b0;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      redirect_valid <= 1'b0;
      misalign_exc   <= 1'b0;
    end else if (stall) begin
      redirect_valid <= 1'b0;
      misalign_exc   <= 1'b0;
    end else begin
      mem_valid      <= keep;
      mem_result     <= is_jump ? link : alu_r;
      mem_rs2        <= ex_rs2;
      mem_rd         <= ex_rd;
      mem_funct3     <= ex_funct3;
      mem_reg_write  <= keep && ex_reg_write && !ex_branch;
      mem_mem_read   <= keep && ex_mem_read;
      mem_mem_write  <= keep && ex_mem_write;
      mem_mem_to_reg <= keep && ex_mem_to_reg;
      redirect_valid <= take && !misaligned;
      redirect_pc    <= target;
      misalign_exc   <= take && misaligned;
    end
  end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: a vector table for single-cycle
// resolution plus hand sequences for squash, stall, flush and reset.
module tb_branch_resolve_stage;

  typedef struct {
    logic        v, br, jal, jalr;
    logic [2:0]  f3;
    logic        cf, zf, vf, sf;
    logic [31:0] pc, imm, alu, rs2;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r;
    logic        e_valid;
    logic [31:0] e_res;
    logic        e_rw, e_mr, e_mw, e_m2r, e_redir;
    logic [31:0] e_rpc;
    logic        e_mis, chk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, alu_cf, alu_zf, alu_vf, alu_sf;
  logic [31:0] alu_r, ex_pc, ex_imm, ex_rs2;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_branch, ex_jal, ex_jalr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic [31:0] mem_result, mem_rs2, redirect_pc;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic        redirect_valid, misalign_exc;

  int checks = 0;
  int errors = 0;

  branch_resolve_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_r(alu_r),
    .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_sf(alu_sf),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rs2(mem_rs2),
    .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  vec_t vecs[19];
  vec_t bubble;
  vec_t t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t s);
    ex_valid      = s.v;
    ex_branch     = s.br;
    ex_jal        = s.jal;
    ex_jalr       = s.jalr;
    ex_funct3     = s.f3;
    alu_cf        = s.cf;
    alu_zf        = s.zf;
    alu_vf        = s.vf;
    alu_sf        = s.sf;
    ex_pc         = s.pc;
    ex_imm        = s.imm;
    alu_r         = s.alu;
    ex_rs2        = s.rs2;
    ex_rd         = s.rd;
    ex_reg_write  = s.rw;
    ex_mem_read   = s.mr;
    ex_mem_write  = s.mw;
    ex_mem_to_reg = s.m2r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic v, input logic rw, input logic mr,
                           input logic mw, input logic m2r, input logic rd, input logic mis);
    checkOutput({tag, " mem_valid"}, 32'(mem_valid), 32'(v));
    checkOutput({tag, " mem_reg_write"}, 32'(mem_reg_write), 32'(rw));
    checkOutput({tag, " mem_mem_read"}, 32'(mem_mem_read), 32'(mr));
    checkOutput({tag, " mem_mem_write"}, 32'(mem_mem_write), 32'(mw));
    checkOutput({tag, " mem_mem_to_reg"}, 32'(mem_mem_to_reg), 32'(m2r));
    checkOutput({tag, " redirect_valid"}, 32'(redirect_valid), 32'(rd));
    checkOutput({tag, " misalign_exc"}, 32'(misalign_exc), 32'(mis));
  endtask

  initial begin
    bubble = '{0,0,0,0,0,0,0,0,0,'h0,'h0,'h0,'h0,0,0,0,0,0, 0,'h0,0,0,0,0,0,'h0,0,0};
    //          v br jal jalr f3 cf zf vf sf pc imm alu rs2 rd rw mr mw m2r | ev eres erw emr emw em2r eredir erpc emis chk
    vecs[0]  = '{1,1,0,0,0,0,1,0,0,'h100,'h20,'h0,'h0,0,0,0,0,0,              1,'h0,0,0,0,0,1,'h120,0,1};
    vecs[1]  = '{1,1,0,0,0,0,0,0,0,'h100,'h20,'h5,'h0,0,0,0,0,0,              1,'h5,0,0,0,0,0,'h0,0,1};
    vecs[2]  = '{1,1,0,0,1,0,0,0,0,'h200,'hFFFFFFF0,'h7,'h0,0,0,0,0,0,        1,'h7,0,0,0,0,1,'h1F0,0,1};
    vecs[3]  = '{1,1,0,0,6,0,0,0,0,'h300,'h8,'h9,'h0,0,0,0,0,0,               1,'h9,0,0,0,0,1,'h308,0,1};
    vecs[4]  = '{1,1,0,0,7,0,0,0,0,'h300,'h8,'h9,'h0,0,0,0,0,0,               1,'h9,0,0,0,0,0,'h0,0,1};
    vecs[5]  = '{1,1,0,0,6,1,0,0,0,'h300,'h8,'hA,'h0,0,0,0,0,0,               1,'hA,0,0,0,0,0,'h0,0,1};
    vecs[6]  = '{1,1,0,0,7,1,0,0,0,'h300,'h40,'hA,'h0,0,0,0,0,0,              1,'hA,0,0,0,0,1,'h340,0,1};
    vecs[7]  = '{1,1,0,0,4,0,0,0,1,'h500,'h10,'hB,'h0,0,0,0,0,0,              1,'hB,0,0,0,0,1,'h510,0,1};
    vecs[8]  = '{1,1,0,0,5,0,0,1,1,'h500,'h14,'hC,'h0,0,0,0,0,0,              1,'hC,0,0,0,0,1,'h514,0,1};
    vecs[9]  = '{1,1,0,0,5,0,0,0,1,'h500,'h14,'hD,'h0,0,0,0,0,0,              1,'hD,0,0,0,0,0,'h0,0,1};
    vecs[10] = '{1,1,0,0,2,0,1,0,0,'h500,'h14,'h0,'h0,0,0,0,0,0,              1,'h0,0,0,0,0,0,'h0,0,1};
    vecs[11] = '{1,0,0,1,0,0,0,0,0,'h400,'h0,'h2003,'h0,1,1,0,0,0,            0,'h0,0,0,0,0,0,'h0,1,0};
    vecs[12] = '{1,0,0,1,0,0,0,0,0,'h400,'h0,'h2001,'h0,1,1,0,0,0,            1,'h404,1,0,0,0,1,'h2000,0,1};
    vecs[13] = '{1,0,1,0,0,0,0,0,0,'hFFFFFFF8,'h10,'h0,'h0,2,1,0,0,0,         1,'hFFFFFFFC,1,0,0,0,1,'h8,0,1};
    vecs[14] = '{1,0,0,0,0,0,0,0,0,'h600,'h0,'h1234,'h0,5,1,0,0,0,            1,'h1234,1,0,0,0,0,'h0,0,1};
    vecs[15] = '{1,0,0,0,2,0,0,0,0,'h604,'h80,'h80,'h0,6,1,1,0,1,             1,'h80,1,1,0,1,0,'h0,0,1};
    vecs[16] = '{1,0,0,0,2,0,0,0,0,'h608,'h4,'h84,'hDEAD,0,0,0,1,0,           1,'h84,0,0,1,0,0,'h0,0,1};
    vecs[17] = '{1,1,0,0,0,0,1,0,0,'h100,'h22,'h0,'h0,0,0,0,0,0,              0,'h0,0,0,0,0,0,'h0,1,0};
    vecs[18] = '{0,0,0,0,0,0,0,0,0,'h700,'h0,'h99,'h0,7,1,0,0,0,              0,'h0,0,0,0,0,0,'h0,0,0};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    applyStimulus(bubble);
    step(); step();
    checkCtrl("reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset mem_result", mem_result, 32'h0);
    checkOutput("reset redirect_pc", redirect_pc, 32'h0);
    rst = 1'b0;

    // Each vector follows a bubble so no earlier redirect squashes it.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(bubble);
      step();
      applyStimulus(vecs[i]);
      step();
      checkCtrl($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_rw, vecs[i].e_mr,
                vecs[i].e_mw, vecs[i].e_m2r, vecs[i].e_redir, vecs[i].e_mis);
      if (vecs[i].chk) begin
        checkOutput($sformatf("vec%0d mem_result", i), mem_result, vecs[i].e_res);
        checkOutput($sformatf("vec%0d mem_rs2", i), mem_rs2, vecs[i].rs2);
        checkOutput($sformatf("vec%0d mem_rd", i), 32'(mem_rd), 32'(vecs[i].rd));
        checkOutput($sformatf("vec%0d mem_funct3", i), 32'(mem_funct3), 32'(vecs[i].f3));
      end
      if (vecs[i].e_redir)
        checkOutput($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
    end

    // Taken BEQ, then the following instruction is wrong-path and squashed.
    applyStimulus(bubble); step();
    applyStimulus(vecs[0]); step();
    checkOutput("seqA redirect_pc", redirect_pc, 32'h120);
    t = vecs[14];
    applyStimulus(t); step();
    checkCtrl("seqA squash", 0, 0, 0, 0, 0, 0, 0);
    step();
    checkCtrl("seqA resume", 1, 1, 0, 0, 0, 0, 0);

    // JAL held under stall: registers hold, one redirect on the capture edge.
    applyStimulus(bubble); step();
    t = bubble; t.v = 1; t.alu = 'h55; t.rd = 3; t.rw = 1;
    applyStimulus(t); step();
    t = bubble; t.v = 1; t.jal = 1; t.pc = 'h1000; t.imm = 'h100; t.rd = 1; t.rw = 1;
    applyStimulus(t);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkCtrl($sformatf("seqB stall%0d", c), 1, 1, 0, 0, 0, 0, 0);
      checkOutput($sformatf("seqB stall%0d mem_result", c), mem_result, 32'h55);
      checkOutput($sformatf("seqB stall%0d mem_rd", c), 32'(mem_rd), 32'd3);
    end
    stall = 1'b0;
    step();
    checkCtrl("seqB capture", 1, 1, 0, 0, 0, 1, 0);
    checkOutput("seqB redirect_pc", redirect_pc, 32'h1100);
    checkOutput("seqB mem_result", mem_result, 32'h1004);
    step();
    checkCtrl("seqB no repeat", 0, 0, 0, 0, 0, 0, 0);

    // Flush beats stall on a valid ADD.
    applyStimulus(bubble); step();
    applyStimulus(vecs[14]); step();
    checkCtrl("seqC add", 1, 1, 0, 0, 0, 0, 0);
    stall = 1'b1; flush = 1'b1;
    step();
    checkCtrl("seqC flush", 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b0; flush = 1'b0;

    // Reset during a redirect pulse clears every output.
    applyStimulus(bubble); step();
    t = bubble; t.v = 1; t.jal = 1; t.pc = 'h2000; t.imm = 'h40; t.rd = 9; t.rw = 1;
    t.rs2 = 'hBEEF; t.f3 = 3'b010;
    applyStimulus(t); step();
    checkCtrl("seqD pulse", 1, 1, 0, 0, 0, 1, 0);
    checkOutput("seqD redirect_pc", redirect_pc, 32'h2040);
    rst = 1'b1;
    step();
    checkCtrl("seqD reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seqD mem_result", mem_result, 32'h0);
    checkOutput("seqD mem_rs2", mem_rs2, 32'h0);
    checkOutput("seqD mem_rd", 32'(mem_rd), 32'h0);
    checkOutput("seqD mem_funct3", 32'(mem_funct3), 32'h0);
    checkOutput("seqD redirect_pc", redirect_pc, 32'h0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
